// File: rtl/otter_icache.sv
// otter_icache: direct-mapped, read-only instruction cache for the OTTER fetch stage.
// Hits return the word combinationally in the same cycle. A miss stalls the
// pipeline while the 4-word line is refilled over a request/grant + rvalid
// beat handshake.
// Optional build macro: OTTER_ICACHE_STATS_EN adds saturating hit/miss
// counters. When it is undefined, hit_cnt and miss_cnt are tied to zero.
module otter_icache #(
  parameter int LINES   = 16,
  parameter int INDEX_W = $clog2(LINES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] pc_addr,
  input  logic        invalidate,
  output logic [31:0] ir,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int TAG_W = 32 - 4 - INDEX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_t;

  state_t               state;
  logic [LINES-1:0]     valid;
  logic [1:0]           beat;
  logic                 kill;
  logic [INDEX_W-1:0]   fill_index;
  logic [TAG_W-1:0]     fill_tag;

  logic [31:0]          data_arr [LINES][4];
  logic [TAG_W-1:0]     tag_arr  [LINES];

  // Address fields; the byte offset bits are not used by a word fetch.
  logic [1:0]           offset;
  logic [INDEX_W-1:0]   index;
  logic [TAG_W-1:0]     tag;
  logic                 hit;
  logic                 unused_byte_bits;

  assign offset           = pc_addr[3:2];
  assign index            = pc_addr[4 +: INDEX_W];
  assign tag              = pc_addr[31 -: TAG_W];
  assign unused_byte_bits = &{1'b0, pc_addr[1:0]};

  assign hit = valid[index] && (tag_arr[index] == tag);

  // Output word and stall are combinational so a hit costs no cycles.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    ir    = data_arr[index][offset];
    stall = 1'b1;
    if (state == IDLE) begin
      stall = en && !hit;
    end
  end

  // Fill controller: state, valid bits, kill flag and the registered memory request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      valid      <= '0;
      beat       <= 2'd0;
      kill       <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= 32'd0;
      fill_index <= '0;
      fill_tag   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments; later assignments in the block win.
      case (state)
        IDLE: begin
          if (invalidate) begin
            valid <= '0;
          end
          if (en && !hit) begin
            fill_index <= index;
            fill_tag   <= tag;
            mem_addr   <= {tag, index, 4'b0000};
            mem_req    <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (invalidate) begin
            valid <= '0;
            kill  <= 1'b1;
          end
          if (mem_gnt) begin
            mem_req <= 1'b0;
            beat    <= 2'd0;
            state   <= FILL;
          end
        end
        FILL: begin
          if (invalidate) begin
            valid <= '0;
            kill  <= 1'b1;
          end
          if (mem_rvalid) begin
            beat <= beat + 2'd1;
            if (beat == 2'd3) begin
              // A same-edge invalidate beats the line becoming valid.
              if (!kill && !invalidate) begin
                valid[fill_index] <= 1'b1;
              end
              kill  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Data and tag arrays capture fill beats; storage is plain RAM.
  always_ff @(posedge clk) begin
    // NOTE: memories are not reset; the valid bits alone decide whether contents are meaningful.
    if (state == FILL && mem_rvalid) begin
      data_arr[fill_index][beat] <= mem_rdata;
      if (beat == 2'd3) begin
        tag_arr[fill_index] <= fill_tag;
      end
    end
  end

`ifdef OTTER_ICACHE_STATS_EN
  // Saturating statistics counters; invalidate leaves them untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else begin
      if (state == IDLE && en && hit && hit_cnt != 32'hFFFF_FFFF) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (state == IDLE && en && !hit && miss_cnt != 32'hFFFF_FFFF) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`else
  assign hit_cnt  = 32'd0;
  assign miss_cnt = 32'd0;
`endif

endmodule

// File: doc/otter_icache.md
# otter_icache

Direct-mapped, read-only instruction cache between the OTTER fetch stage PC and main memory. Returns the instruction word for the current fetch address in the same cycle on a hit. Asserts STALL on a miss while it refills the full 4-word line over a request/beat memory handshake. Its STALL output is ORed into the pipeline's global stall, so PC, IF and DE registers hold until the word is available.

## Interface
- LINES, 16, number of cache lines; power of two, ≥2; INDEX_W = log2(LINES)
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- EN  in  1  fetch request this cycle; when low, no miss is started and no statistics are counted
- PC_ADDR  in  32  byte fetch address; bits [1:0] ignored
- INVALIDATE  in  1  one-cycle pulse; clears every valid bit (fence.i)
- IR  out  32  instruction word; valid only when STALL=0
- STALL  out  1  high while the addressed word is not available
- MEM_REQ  out  1  line-fill request, held until granted
- MEM_ADDR  out  32  line-aligned fill address, {tag,index,4'b0000}
- MEM_GNT  in  1  memory accepted the request this cycle
- MEM_RVALID  in  1  one fill word present on MEM_RDATA
- MEM_RDATA  in  32  fill word, delivered in order, word 0 first
- HIT_CNT  out  32  hit counter (see Configuration)
- MISS_CNT  out  32  miss counter (see Configuration)

## Operation
- Address split: offset = PC_ADDR[3:2], index = PC_ADDR[4+INDEX_W-1:4], tag = PC_ADDR[31:4+INDEX_W].
- Storage: data array LINES×4×32 and tag array LINES×tag width, read combinationally and not reset. Per-line valid bits are flops and are reset.
- hit = valid[index] && tag_arr[index]==tag.
- FSM states: IDLE, REQ, FILL.
- IDLE: IR = data[index][offset]. STALL = EN && !hit. On EN && !hit, latch the fill index and tag, then go to REQ.
- REQ: STALL=1. MEM_REQ=1 and MEM_ADDR holds the latched line address. On MEM_GNT, clear the beat counter and go to FILL.
- FILL: STALL=1. Each MEM_RVALID writes MEM_RDATA into data[fill_index][beat], then beat increments.
  - On the beat-3 write, write tag_arr[fill_index] and set valid[fill_index] unless the kill flag is set, then go to IDLE.
  - MEM_RVALID in IDLE or REQ is ignored.
- A fill always targets the latched index and tag. PC_ADDR changes during REQ or FILL do not affect the fill in progress.
- INVALIDATE:
  - In IDLE, clears all valid bits at the edge.
  - In REQ or FILL, clears all valid bits and sets the kill flag. The fill still completes its 4 beats so the memory handshake closes, but the line is not marked valid. The kill flag clears on return to IDLE.
  - INVALIDATE on the same edge as the beat-3 write: invalidate wins and the line stays invalid.
- Back-pressure: STALL is combinational from state, hit and EN. Upstream registers IR only when the global stall is low.

## Timing
- Reset values: state=IDLE, all valid=0, beat=0, kill=0, MEM_REQ=0, MEM_ADDR=0, counters=0. STALL=EN (every line misses). IR is don't-care.
- Hit latency is 0 cycles: IR is valid in the same cycle as PC_ADDR.
- Miss sequence, with GNT in the first REQ cycle and RVALID on 4 consecutive cycles:
  - cycle 0: IDLE miss, STALL=1
  - cycle 1: REQ, GNT
  - cycles 2–5: FILL beats
  - cycle 6: IDLE hit, STALL=0
  - Minimum penalty is 6 stall cycles. Each extra GNT or RVALID wait cycle adds one.
- Reset asserted mid-fill aborts immediately to IDLE with all lines invalid. Any late MEM_RVALID beats are ignored.
- Index wrap: no special case, the address is split modulo the fields. A PC of 0xFFFF_FFFC maps to the last index, offset 3.

## Configuration
- OTTER_ICACHE_STATS_EN defined:
  - HIT_CNT increments on every cycle with state=IDLE && EN && hit.
  - MISS_CNT increments on every IDLE→REQ transition.
  - Both saturate at 0xFFFF_FFFF and reset to 0. INVALIDATE does not clear them.
- Not defined: counters are not built, and HIT_CNT and MISS_CNT are tied to 0.

## Test plan
- Cold miss at reset release:
  - Stimulus: EN=1, PC=0x0000_0000; memory grants immediately and returns 0x11,0x22,0x33,0x44 on consecutive cycles.
  - Required: MEM_ADDR=0x0; STALL high for exactly 6 cycles; then IR=0x11. PC=0x4, 0x8, 0xC then give 0x22, 0x33, 0x44 with STALL=0.
- Conflict eviction (LINES=16):
  - Stimulus: fill 0x0000_0000, then fetch 0x0000_0100 (same index 0, different tag).
  - Required: miss, MEM_ADDR=0x100, refill. Refetching 0x0 misses again.
- Delayed handshake:
  - Stimulus: MEM_GNT 3 cycles late; one idle cycle between each RVALID beat.
  - Required: STALL spans 12 cycles; data lands in the correct word slots.
- INVALIDATE during FILL:
  - Stimulus: pulse INVALIDATE after beat 1.
  - Required: the fill finishes all 4 beats, then the same PC misses again (second MEM_REQ issued). Previously valid lines also miss.
- PC change mid-fill:
  - Stimulus: PC moves from 0x40 to 0x80 during REQ.
  - Required: the fill still writes index 4 (line 0x40). Index 8 then misses separately.
- Statistics (macro defined):
  - Stimulus: 1 miss followed by 7 hitting fetches.
  - Required: MISS_CNT=1, HIT_CNT=7 (the post-fill hit cycle counts). With the macro undefined, both read 0.
